// File: rtl/code_lock_ctrl_if.sv
// Keypad-side handshake bundle for the combination-lock sequencer.
// The slave modport is the controller's view; the master modport drives the keypad strobes.
interface code_lock_ctrl_if #(
  parameter int unsigned DW = 4
);
  logic          key_valid;
  logic [DW-1:0] key_val;
  logic          key_clr;
  logic          lock_req;
  logic          set_req;
  logic          unlock;
  logic          alarm;
  logic [3:0]    fail_cnt;
  logic [2:0]    dig_cnt;
  logic [2:0]    state;

  modport slave (
    input  key_valid, key_val, key_clr, lock_req, set_req,
    output unlock, alarm, fail_cnt, dig_cnt, state
  );

  modport master (
    output key_valid, key_val, key_clr, lock_req, set_req,
    input  unlock, alarm, fail_cnt, dig_cnt, state
  );
endinterface

// File: rtl/code_lock_ctrl.sv
// Combination-lock sequencer: collects keypad digits, checks them against a
// programmable code, and runs the unlock, relock-timeout and lockout phases.
module code_lock_ctrl #(
  parameter int unsigned               DIGITS       = 4,
  parameter int unsigned               DW           = 4,
  parameter logic [DIGITS*DW-1:0]      DEFAULT_CODE = 16'h1234,
  parameter int unsigned               MAX_FAIL     = 3,
  parameter int unsigned               UNLOCK_CYC   = 500,
  parameter int unsigned               LOCKOUT_CYC  = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  code_lock_ctrl_if.slave        bus
);

  localparam int unsigned CW   = DIGITS * DW;
  localparam int unsigned TMAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYC - 1);
  localparam logic [2:0]    DIG_LAST     = 3'(DIGITS);
  localparam logic [3:0]    FAIL_LIM     = 4'(MAX_FAIL);

  localparam logic [2:0] S_LOCKED  = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_PROGRAM = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  logic [2:0]    state_q,  state_d;
  logic [CW-1:0] buf_q,    buf_d;
  logic [CW-1:0] code_q,   code_d;
  logic [2:0]    dig_q,    dig_d;
  logic [3:0]    fail_q,   fail_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic          unlock_q, unlock_d;
  logic          alarm_q,  alarm_d;

  logic [CW-1:0] shifted_c;
  logic [2:0]    dig_inc_c;
  logic          last_dig_c;
  logic [3:0]    fail_inc_c;
  logic          timer_zero_c;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    code_d       = code_q;
    dig_d        = dig_q;
    fail_d       = fail_q;
    timer_d      = timer_q;
    shifted_c    = (buf_q << DW) | CW'(bus.key_val);
    dig_inc_c    = dig_q + 3'd1;
    last_dig_c   = (dig_inc_c == DIG_LAST);
    fail_inc_c   = fail_q + 4'd1;
    timer_zero_c = (timer_q == '0);

    case (state_q)
      S_LOCKED: begin
        if (bus.key_valid) begin
          buf_d   = shifted_c;
          dig_d   = dig_inc_c;
          state_d = last_dig_c ? S_CHECK : S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (bus.key_clr) begin
          buf_d   = '0;
          dig_d   = '0;
          state_d = S_LOCKED;
        end else if (bus.key_valid) begin
          buf_d = shifted_c;
          dig_d = dig_inc_c;
          if (last_dig_c) state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        buf_d = '0;
        dig_d = '0;
        if (buf_q == code_q) begin
          fail_d  = '0;
          timer_d = UNLOCK_LOAD;
          state_d = S_OPEN;
        end else begin
          fail_d = fail_inc_c;
          if (fail_inc_c >= FAIL_LIM) begin
            timer_d = LOCKOUT_LOAD;
            state_d = S_LOCKOUT;
          end else begin
            state_d = S_LOCKED;
          end
        end
      end

      // Timer is left untouched on the set_req cycle so it enters PROGRAM frozen.
      S_OPEN: begin
        if (bus.lock_req || timer_zero_c) begin
          state_d = S_LOCKED;
        end else if (bus.set_req) begin
          state_d = S_PROGRAM;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_PROGRAM: begin
        if (bus.lock_req) begin
          buf_d   = '0;
          dig_d   = '0;
          state_d = S_LOCKED;
        end else if (bus.key_clr) begin
          buf_d   = '0;
          dig_d   = '0;
          timer_d = UNLOCK_LOAD;
          state_d = S_OPEN;
        end else if (bus.key_valid) begin
          if (last_dig_c) begin
            code_d  = shifted_c;
            buf_d   = '0;
            dig_d   = '0;
            timer_d = UNLOCK_LOAD;
            state_d = S_OPEN;
          end else begin
            buf_d = shifted_c;
            dig_d = dig_inc_c;
          end
        end
      end

      S_LOCKOUT: begin
        if (timer_zero_c) begin
          fail_d  = '0;
          state_d = S_LOCKED;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        buf_d   = '0;
        dig_d   = '0;
        state_d = S_LOCKED;
      end
    endcase

    unlock_d = (state_d == S_OPEN) || (state_d == S_PROGRAM);
    alarm_d  = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOCKED;
      buf_q    <= '0;
      code_q   <= DEFAULT_CODE;
      dig_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      code_q   <= code_d;
      dig_q    <= dig_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
    end
  end

  assign bus.unlock   = unlock_q;
  assign bus.alarm    = alarm_q;
  assign bus.fail_cnt = fail_q;
  assign bus.dig_cnt  = dig_q;
  assign bus.state    = state_q;

endmodule
